alu_pipe_param: RTL and testbench

//  Pipelined, width-parametrised ALU with valid/ready handshake and registered flags.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_pipe_param_if.sv | 41 ++++
 rtl/alu_core_comb.sv | 83 ++++++++
 rtl/alu_pipe_param.sv | 112 +++++++++++
 tb/tb_alu_pipe_param.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU: opcode width, opcode encodings
// and a helper that tells legal opcodes apart from the reserved range.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ROL = 4'd0;
    localparam logic [OP_W-1:0] OP_ROR = 4'd1;
    localparam logic [OP_W-1:0] OP_MAX = 4'd2;
    localparam logic [OP_W-1:0] OP_MIN = 4'd3;
    localparam logic [OP_W-1:0] OP_AND = 4'd4;
    localparam logic [OP_W-1:0] OP_ADD = 4'd5;
    localparam logic [OP_W-1:0] OP_SUB = 4'd6;

    // Opcodes 7..15 are reserved and treated as illegal.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_SUB);
    endfunction

endpackage

// File: rtl/alu_pipe_param_if.sv
// ---------------------------------------------------------------------------
// alu_pipe_param_if
// Operand/result handshake bundle of the pipelined ALU.
//   master : operand source + result sink (drives beats, drives outReady)
//   slave  : the ALU (drives inReady, result beat and flags)
// Signals: inValid/inReady/opcode/input1/input2/shiftValue on the operand
// side; outValid/outReady/result/carryFlag/zeroFlag/overFlowFlag/illegalOp
// on the result side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface alu_pipe_param_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 5
);
    logic             inValid;
    logic             inReady;
    logic [OP_W-1:0]  opcode;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [SHW-1:0]   shiftValue;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic             carryFlag;
    logic             zeroFlag;
    logic             overFlowFlag;
    logic             illegalOp;

    modport master (
        output inValid, opcode, input1, input2, shiftValue, outReady,
        input  inReady, outValid, result, carryFlag, zeroFlag, overFlowFlag, illegalOp
    );

    modport slave (
        input  inValid, opcode, input1, input2, shiftValue, outReady,
        output inReady, outValid, result, carryFlag, zeroFlag, overFlowFlag, illegalOp
    );

endinterface

// File: rtl/alu_core_comb.sv
// ---------------------------------------------------------------------------
// alu_core_comb
// Purely combinational execute unit sitting between the operand stage and
// the result stage.
//   opcode    : operation select (see alu_pkg)
//   a, b      : operands
//   shift_amt : rotate amount, reduced modulo WIDTH
//   result    : operation result (0 for illegal opcodes)
//   carry     : ADD carry-out / SUB borrow, else 0
//   overflow  : ADD/SUB signed overflow, else 0
//   zero      : result == 0
//   illegal   : opcode outside the defined set
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHW        = 5,
    parameter int SIGNED_CMP = 0
) (
    input  logic [OP_W-1:0]  opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shift_amt,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);
    localparam int MSB = WIDTH - 1;

    logic [31:0]      amt;
    logic [WIDTH-1:0] rol_val;
    logic [WIDTH-1:0] ror_val;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             a_gt_b;

    always_comb begin
        amt = 32'(shift_amt) % 32'(WIDTH);
        // A shift by the full width yields 0 in SV, so amt==0 passes A through
        // cleanly without any out-of-range part-select.
        rol_val = (a << amt) | (a >> (32'(WIDTH) - amt));
        ror_val = (a >> amt) | (a << (32'(WIDTH) - amt));
        sum     = {1'b0, a} + {1'b0, b};
        // The extra top bit of the widened difference is the borrow.
        diff    = {1'b0, a} - {1'b0, b};
        if (SIGNED_CMP != 0) begin
            a_gt_b = ($signed(a) > $signed(b));
        end else begin
            a_gt_b = (a > b);
        end
    end

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        illegal  = !is_legal_op(opcode);
        case (opcode)
            OP_ROL: result = rol_val;
            OP_ROR: result = ror_val;
            OP_MAX: result = a_gt_b ? a : b;   // ties return A
            OP_MIN: result = (a_gt_b || a == b) ? ((a == b) ? a : b) : a;
            OP_AND: result = a & b;
            OP_ADD: begin
                result   = sum[MSB:0];
                carry    = sum[WIDTH];
                overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result   = diff[MSB:0];
                carry    = diff[WIDTH];
                overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_pipe_param.sv
// ---------------------------------------------------------------------------
// alu_pipe_param
// Two-stage pipelined ALU with valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, flushes both stages
//   bus   : alu_pipe_param_if.slave (operand beat in, result beat out)
// Stage 1 captures opcode/operands, stage 2 captures result and flags from
// alu_core_comb. Each stage advances when empty or when the stage after it
// advances; inReady is combinational from outReady (no skid buffer).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module alu_pipe_param
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHW        = 5,
    parameter int SIGNED_CMP = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_pipe_param_if.slave bus
);
    logic             valid_s1_reg;
    logic [OP_W-1:0]  op_s1_reg;
    logic [WIDTH-1:0] a_s1_reg;
    logic [WIDTH-1:0] b_s1_reg;
    logic [SHW-1:0]   sh_s1_reg;

    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             zero_reg;
    logic             ovf_reg;
    logic             illegal_reg;

    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_ovf;
    logic             core_zero;
    logic             core_illegal;

    logic             s2_advance;
    logic             s1_advance;

    assign s2_advance = !out_valid_reg || bus.outReady;
    assign s1_advance = !valid_s1_reg || s2_advance;
    assign bus.inReady = s1_advance;

    alu_core_comb #(
        .WIDTH      (WIDTH),
        .SHW        (SHW),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_core (
        .opcode    (op_s1_reg),
        .a         (a_s1_reg),
        .b         (b_s1_reg),
        .shift_amt (sh_s1_reg),
        .result    (core_result),
        .carry     (core_carry),
        .overflow  (core_ovf),
        .zero      (core_zero),
        .illegal   (core_illegal)
    );

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1_reg <= 1'b0;
            op_s1_reg    <= '0;
            a_s1_reg     <= '0;
            b_s1_reg     <= '0;
            sh_s1_reg    <= '0;
        end else if (s1_advance) begin
            valid_s1_reg <= bus.inValid;
            if (bus.inValid) begin
                op_s1_reg <= bus.opcode;
                a_s1_reg  <= bus.input1;
                b_s1_reg  <= bus.input2;
                sh_s1_reg <= bus.shiftValue;
            end
        end
    end

    // Stage 2: result/flag capture; holds while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (s2_advance) begin
            out_valid_reg <= valid_s1_reg;
            if (valid_s1_reg) begin
                result_reg  <= core_result;
                carry_reg   <= core_carry;
                zero_reg    <= core_zero;
                ovf_reg     <= core_ovf;
                illegal_reg <= core_illegal;
            end
        end
    end

    assign bus.outValid     = out_valid_reg;
    assign bus.result       = result_reg;
    assign bus.carryFlag    = carry_reg;
    assign bus.zeroFlag     = zero_reg;
    assign bus.overFlowFlag = ovf_reg;
    assign bus.illegalOp    = illegal_reg;

endmodule

// File: tb/tb_alu_pipe_param.sv
`timescale 1ns/1ps
module tb_alu_pipe_param;
    import alu_pkg::*;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe_param_if #(.WIDTH(8), .SHW(5)) bus  ();
    alu_pipe_param_if #(.WIDTH(8), .SHW(5)) bus2 ();

    // Unsigned-compare instance
    alu_pipe_param #(.WIDTH(8), .SHW(5), .SIGNED_CMP(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Signed-compare instance, fed the same stimulus
    alu_pipe_param #(.WIDTH(8), .SHW(5), .SIGNED_CMP(1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    assign bus2.inValid    = bus.inValid;
    assign bus2.opcode     = bus.opcode;
    assign bus2.input1     = bus.input1;
    assign bus2.input2     = bus.input2;
    assign bus2.shiftValue = bus.shiftValue;
    assign bus2.outReady   = bus.outReady;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One beat through an idle pipe with the sink always ready.
    // Returns dut result, dut flags {carry,zero,ovf,illegal}, dut_s result.
    task automatic send_one(input string tag, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [4:0] sh,
                            output logic [7:0] r1, output logic [3:0] f1, output logic [7:0] r2);
        @(negedge clk);
        bus.inValid    = 1'b1;
        bus.opcode     = op;
        bus.input1     = a;
        bus.input2     = b;
        bus.shiftValue = sh;
        bus.outReady   = 1'b1;
        #1;
        check({tag, "_inready"}, 32'(bus.inReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.inValid = 1'b0;
        check({tag, "_lat_s1"}, 32'(bus.outValid), 32'd0);
        @(negedge clk);
        check({tag, "_lat_s2"}, 32'(bus.outValid), 32'd1);
        r1 = bus.result;
        f1 = {bus.carryFlag, bus.zeroFlag, bus.overFlowFlag, bus.illegalOp};
        r2 = bus2.result;
        $display("txn %s op=%0d a=0x%02h b=0x%02h sh=%0d -> res=0x%02h flags=%b res_signed=0x%02h",
                 tag, op, a, b, sh, r1, f1, r2);
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [4:0] sh,
                           input logic [7:0] exp_res, input logic [3:0] exp_flags,
                           input logic [7:0] exp_res_signed);
        logic [7:0] r1;
        logic [3:0] f1;
        logic [7:0] r2;
        send_one(tag, op, a, b, sh, r1, f1, r2);
        check({tag, "_res"}, 32'(r1), 32'(exp_res));
        check({tag, "_flags"}, 32'(f1), 32'(exp_flags));
        check({tag, "_res_signed"}, 32'(r2), 32'(exp_res_signed));
    endtask

    logic [7:0] bp_a   [6] = '{8'h10, 8'h20, 8'hFF, 8'h7F, 8'h00, 8'h33};
    logic [7:0] bp_b   [6] = '{8'h01, 8'h22, 8'h02, 8'h7F, 8'h00, 8'h44};
    logic [7:0] bp_exp [6] = '{8'h11, 8'h42, 8'h01, 8'hFE, 8'h00, 8'h77};

    initial begin
        int sent;
        int drained;
        int last_drain;

        rst_n          = 1'b0;
        bus.inValid    = 1'b0;
        bus.opcode     = '0;
        bus.input1     = '0;
        bus.input2     = '0;
        bus.shiftValue = '0;
        bus.outReady   = 1'b1;

        // Reset state
        #1;
        check("rst_outvalid", 32'(bus.outValid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", 32'({bus.carryFlag, bus.zeroFlag, bus.overFlowFlag, bus.illegalOp}), 32'd0);
        check("rst_inready", 32'(bus.inReady), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //      tag          op      A      B      sh  res    {c,z,o,i} res(signed cmp)
        run_vec("add_ff_01", OP_ADD, 8'hFF, 8'h01, 0,  8'h00, 4'b1100, 8'h00);
        run_vec("add_7f_01", OP_ADD, 8'h7F, 8'h01, 0,  8'h80, 4'b0010, 8'h80);
        run_vec("sub_05_07", OP_SUB, 8'h05, 8'h07, 0,  8'hFE, 4'b1000, 8'hFE);
        run_vec("sub_80_01", OP_SUB, 8'h80, 8'h01, 0,  8'h7F, 4'b0010, 8'h7F);
        run_vec("rol_81_1",  OP_ROL, 8'h81, 8'h00, 1,  8'h03, 4'b0000, 8'h03);
        run_vec("ror_81_9",  OP_ROR, 8'h81, 8'h00, 9,  8'hC0, 4'b0000, 8'hC0);
        run_vec("rol_5a_0",  OP_ROL, 8'h5A, 8'h00, 0,  8'h5A, 4'b0000, 8'h5A);
        run_vec("ror_5a_16", OP_ROR, 8'h5A, 8'h00, 16, 8'h5A, 4'b0000, 8'h5A);
        run_vec("rol_5a_31", OP_ROL, 8'h5A, 8'h00, 31, 8'h2D, 4'b0000, 8'h2D);
        run_vec("max_80_01", OP_MAX, 8'h80, 8'h01, 0,  8'h80, 4'b0000, 8'h01);
        run_vec("min_80_01", OP_MIN, 8'h80, 8'h01, 0,  8'h01, 4'b0000, 8'h80);
        run_vec("max_05_09", OP_MAX, 8'h05, 8'h09, 0,  8'h09, 4'b0000, 8'h09);
        run_vec("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 0,  8'h30, 4'b0000, 8'h30);
        run_vec("and_0f_f0", OP_AND, 8'h0F, 8'hF0, 0,  8'h00, 4'b0100, 8'h00);
        run_vec("illegal_9", 4'd9,   8'hFF, 8'hFF, 3,  8'h00, 4'b0101, 8'h00);
        run_vec("illegal_f", 4'd15,  8'h12, 8'h34, 0,  8'h00, 4'b0101, 8'h00);

        // Backpressure: 6 ADD beats, sink stalls in cycles 3..5
        sent       = 0;
        drained    = 0;
        last_drain = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            bus.outReady = !(c >= 3 && c <= 5);
            if (sent < 6) begin
                bus.inValid = 1'b1;
                bus.opcode  = OP_ADD;
                bus.input1  = bp_a[sent];
                bus.input2  = bp_b[sent];
            end else begin
                bus.inValid = 1'b0;
            end
            #1;
            if (c == 3) begin
                check("bp_inready_low", 32'(bus.inReady), 32'd0);
            end
            if (c >= 3 && c <= 5) begin
                check("bp_hold_valid", 32'(bus.outValid), 32'd1);
                check("bp_hold_result", 32'(bus.result), 32'(bp_exp[1]));
            end
            if (bus.outValid && bus.outReady) begin
                if (drained < 6) begin
                    check("bp_data", 32'(bus.result), 32'(bp_exp[drained]));
                    $display("txn bp beat %0d cycle %0d res=0x%02h", drained, c, bus.result);
                end else begin
                    check("bp_extra_beat", 32'(drained), 32'd5);
                end
                drained++;
                last_drain = c;
            end
            if (bus.inValid && bus.inReady) sent++;
        end
        check("bp_drained", 32'(drained), 32'd6);
        check("bp_last_cycle", 32'(last_drain), 32'd10);

        // Reset with two beats in flight
        @(negedge clk);
        bus.outReady   = 1'b1;
        bus.inValid    = 1'b1;
        bus.opcode     = OP_ADD;
        bus.input1     = 8'h01;
        bus.input2     = 8'h02;
        @(negedge clk);
        bus.input1     = 8'h03;
        bus.input2     = 8'h04;
        @(negedge clk);
        bus.inValid    = 1'b0;
        check("rst_mid_pre_valid", 32'(bus.outValid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outvalid", 32'(bus.outValid), 32'd0);
        check("rst_mid_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_no_stale", 32'(bus.outValid), 32'd0);
        end
        $display("txn reset mid-flight done");

        // Pipe usable again after reset
        run_vec("post_rst_add", OP_ADD, 8'h40, 8'h41, 0, 8'h81, 4'b0010, 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
